// File: rtl/pipelined_barrel_shifter_if.sv
// Request/result bundle for the pipelined barrel shifter.
// Valid/ready: a beat moves on a rising edge where valid and ready are both 1; valid and its payload hold until then.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_carry
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic shifter (SLL/SRL/SRA/ROR) with zero and carry-out flags.
// S0 input register, optional S1 after the upper mux levels, SO output register; one global advance.
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHW     = $clog2(WIDTH),
    parameter int MID_REG = 1
) (
    input logic                       clock,
    input logic                       reset_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int UPPER = (SHW + 1) / 2;
    localparam int LOWER = SHW - UPPER;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // One mux level shifting by 2^k; returns {carry, data}. The carry is the last bit pushed out,
    // so each enabled level overwrites it and the lowest enabled level wins.
    function automatic logic [WIDTH:0] f_level(
        input logic [WIDTH-1:0] v,
        input logic             c,
        input int               k,
        input logic [1:0]       op,
        input logic             en
    );
        int             amt;
        logic [SHW-1:0] hi_idx;
        logic [SHW-1:0] lo_idx;
        logic [WIDTH-1:0] r;
        logic           co;
        amt    = 1 << k;
        hi_idx = SHW'(WIDTH - amt);
        lo_idx = SHW'(amt - 1);
        r      = v;
        co     = c;
        if (en) begin
            case (op)
                OP_SLL:  begin r = v << amt;                           co = v[hi_idx]; end
                OP_SRL:  begin r = v >> amt;                           co = v[lo_idx]; end
                OP_SRA:  begin r = $signed(v) >>> amt;                 co = v[lo_idx]; end
                default: begin r = (v >> amt) | (v << (WIDTH - amt)); co = v[lo_idx]; end
            endcase
        end
        return {co, r};
    endfunction

    logic w_adv;

    logic             r_s0_valid;
    logic [WIDTH-1:0] r_s0_data;
    logic [SHW-1:0]   r_s0_shamt;
    logic [1:0]       r_s0_op;

    logic [WIDTH:0]   w_up [0:UPPER];
    logic [WIDTH:0]   w_lo [0:LOWER];

    logic             w_s1_valid;
    logic [WIDTH-1:0] w_s1_data;
    logic             w_s1_carry;
    logic [SHW-1:0]   w_s1_shamt;
    logic [1:0]       w_s1_op;

    logic [WIDTH-1:0] w_res_data;
    logic             w_res_carry;

    logic             r_so_valid;
    logic [WIDTH-1:0] r_so_data;
    logic             r_so_zero;
    logic             r_so_carry;

    assign w_adv        = bus.out_ready | ~r_so_valid;
    assign bus.in_ready = reset_n & w_adv;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s0_valid <= 1'b0;
            r_s0_data  <= '0;
            r_s0_shamt <= '0;
            r_s0_op    <= '0;
        end else if (w_adv) begin
            r_s0_valid <= bus.in_valid;
            r_s0_data  <= bus.in_data;
            r_s0_shamt <= bus.in_shamt;
            r_s0_op    <= bus.in_op;
        end
    end

    assign w_up[0] = {1'b0, r_s0_data};

    for (genvar g = 0; g < UPPER; g++) begin : g_upper
        localparam int K = SHW - 1 - g;
        assign w_up[g+1] = f_level(w_up[g][WIDTH-1:0], w_up[g][WIDTH], K, r_s0_op, r_s0_shamt[K]);
    end

    if (MID_REG != 0) begin : g_mid
        logic             r_s1_valid;
        logic [WIDTH-1:0] r_s1_data;
        logic             r_s1_carry;
        logic [SHW-1:0]   r_s1_shamt;
        logic [1:0]       r_s1_op;

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_s1_valid <= 1'b0;
                r_s1_data  <= '0;
                r_s1_carry <= 1'b0;
                r_s1_shamt <= '0;
                r_s1_op    <= '0;
            end else if (w_adv) begin
                r_s1_valid <= r_s0_valid;
                r_s1_data  <= w_up[UPPER][WIDTH-1:0];
                r_s1_carry <= w_up[UPPER][WIDTH];
                r_s1_shamt <= r_s0_shamt;
                r_s1_op    <= r_s0_op;
            end
        end

        assign w_s1_valid = r_s1_valid;
        assign w_s1_data  = r_s1_data;
        assign w_s1_carry = r_s1_carry;
        assign w_s1_shamt = r_s1_shamt;
        assign w_s1_op    = r_s1_op;
    end else begin : g_no_mid
        assign w_s1_valid = r_s0_valid;
        assign w_s1_data  = w_up[UPPER][WIDTH-1:0];
        assign w_s1_carry = w_up[UPPER][WIDTH];
        assign w_s1_shamt = r_s0_shamt;
        assign w_s1_op    = r_s0_op;
    end

    assign w_lo[0] = {w_s1_carry, w_s1_data};

    for (genvar g = 0; g < LOWER; g++) begin : g_lower
        localparam int K = LOWER - 1 - g;
        assign w_lo[g+1] = f_level(w_lo[g][WIDTH-1:0], w_lo[g][WIDTH], K, w_s1_op, w_s1_shamt[K]);
    end

    // A rotate loses no bits; its carry is the bit that last wrapped round, which ends up in the MSB.
    assign w_res_data  = w_lo[LOWER][WIDTH-1:0];
    assign w_res_carry = (w_s1_op == OP_ROR) ? ((|w_s1_shamt) & w_res_data[WIDTH-1])
                                             : w_lo[LOWER][WIDTH];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_so_valid <= 1'b0;
            r_so_data  <= '0;
            r_so_zero  <= 1'b0;
            r_so_carry <= 1'b0;
        end else if (w_adv) begin
            r_so_valid <= w_s1_valid;
            r_so_data  <= w_res_data;
            r_so_zero  <= ~|w_res_data;
            r_so_carry <= w_res_carry;
        end
    end

    assign bus.out_valid = r_so_valid;
    assign bus.out_data  = r_so_data;
    assign bus.out_zero  = r_so_zero;
    assign bus.out_carry = r_so_carry;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: 32-bit/MID_REG=1 instance for full checking, 8-bit/MID_REG=0 smoke instance.
// Inputs change 1 time unit after the rising edge; all DUT outputs are sampled on the falling edge.
module tb_pipelined_barrel_shifter;
    localparam int W    = 32;
    localparam int SW   = 5;
    localparam int LAT  = 3;
    localparam int WB   = 8;
    localparam int SWB  = 3;
    localparam int LATB = 2;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] d;
        logic [SW-1:0] s;
        logic [W-1:0] ed;
        logic         ez;
        logic         ec;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    pipelined_barrel_shifter_if #(.WIDTH(W))  bus_a ();
    pipelined_barrel_shifter_if #(.WIDTH(WB)) bus_b ();

    pipelined_barrel_shifter #(.WIDTH(W), .MID_REG(1)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    pipelined_barrel_shifter #(.WIDTH(WB), .MID_REG(0)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: returns {carry, zero, data} ----------------
    function automatic logic [65:0] ref_shift(input int w, input logic [63:0] din, input int s, input int op);
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] r;
        logic [63:0] sext;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        d    = din & mask;
        c    = 1'b0;
        case (op)
            0: begin
                r = (d << s) & mask;
                if (s > 0) c = |((d >> (w - s)) & 64'd1);
            end
            1: begin
                r = d >> s;
                if (s > 0) c = |((d >> (s - 1)) & 64'd1);
            end
            2: begin
                sext = (|((d >> (w - 1)) & 64'd1)) ? (d | ~mask) : d;
                r    = 64'($signed(sext) >>> s) & mask;
                if (s > 0) c = |((d >> (s - 1)) & 64'd1);
            end
            default: begin
                r = ((d >> s) | (d << (w - s))) & mask;
                if (s > 0) c = |((r >> (w - 1)) & 64'd1);
            end
        endcase
        return {c, (r == 64'd0), r};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    bit           sb_on     = 1'b0;
    int           out_cnt   = 0;
    int           first_out = -1;
    int           last_out  = -1;
    bit           held      = 1'b0;
    logic [W+2:0] held_val;

    always @(negedge clock) begin
        logic [W+1:0] act;
        logic [65:0]  m;
        if (!reset_n) begin
            exp_q.delete();
            held = 1'b0;
        end else if (sb_on) begin
            act = {bus_a.out_carry, bus_a.out_zero, bus_a.out_data};
            if (held) check("hold_stable", 64'({bus_a.out_valid, act}), 64'(held_val));
            held     = bus_a.out_valid & ~bus_a.out_ready;
            held_val = {bus_a.out_valid, act};
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: actual=0x%0h required=none", act);
                end else begin
                    check("result", 64'(act), 64'(exp_q.pop_front()));
                end
                out_cnt++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (bus_a.in_valid && bus_a.in_ready) begin
                m = ref_shift(W, 64'(bus_a.in_data), int'(bus_a.in_shamt), int'(bus_a.in_op));
                exp_q.push_back({m[65], m[64], m[W-1:0]});
            end
        end
    end

    // ---------------- driver tasks (called 1 unit after a rising edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_a(input logic [1:0] op, input logic [W-1:0] d, input logic [SW-1:0] s);
        int waited = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_op    = op;
        bus_a.in_data  = d;
        bus_a.in_shamt = s;
        @(negedge clock);
        while (!bus_a.in_ready && waited < 50) begin
            waited++;
            @(negedge clock);
        end
        if (!bus_a.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: actual=in_ready 0 required=in_ready 1");
        end
        @(posedge clock);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus_a.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid  = 1'b1;
        bus_a.in_op     = v.op;
        bus_a.in_data   = v.d;
        bus_a.in_shamt  = v.s;
        @(negedge clock);
        check($sformatf("vec%0d_in_ready", idx), 64'(bus_a.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus_a.in_valid = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!bus_a.out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(LAT));
        check($sformatf("vec%0d_result", idx),
              64'({bus_a.out_carry, bus_a.out_zero, bus_a.out_data}), 64'({v.ec, v.ez, v.ed}));
        idle(1);
    endtask

    task automatic run_b(input string name, input logic [1:0] op, input logic [WB-1:0] d,
                         input logic [SWB-1:0] s, input logic [WB+1:0] exp);
        int lat;
        bus_b.in_valid = 1'b1;
        bus_b.in_op    = op;
        bus_b.in_data  = d;
        bus_b.in_shamt = s;
        @(posedge clock);
        #1;
        bus_b.in_valid = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!bus_b.out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(LATB));
        check({name, "_result"}, 64'({bus_b.out_carry, bus_b.out_zero, bus_b.out_data}), 64'(exp));
        idle(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[12];
        bit   done;

        vecs[0]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
        vecs[3]  = '{2'b00, 32'hC000_0000, 5'd1,  32'h8000_0000, 1'b0, 1'b1};
        vecs[4]  = '{2'b01, 32'h0000_0003, 5'd1,  32'h0000_0001, 1'b0, 1'b1};
        vecs[5]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 1'b1};
        vecs[6]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 32'h0000_000F, 5'd4,  32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{2'b00, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003, 1'b0, 1'b0};
        vecs[11] = '{2'b10, 32'hF000_0000, 5'd16, 32'hFFFF_F000, 1'b0, 1'b0};

        bus_a.in_valid = 1'b0; bus_a.in_op = '0; bus_a.in_data = '0; bus_a.in_shamt = '0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_op = '0; bus_b.in_data = '0; bus_b.in_shamt = '0;
        bus_b.out_ready = 1'b1;

        // reset state
        @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_out_data",  64'(bus_a.out_data),  64'd0);
        check("rst_out_zero",  64'(bus_a.out_zero),  64'd0);
        check("rst_out_carry", 64'(bus_a.out_carry), 64'd0);
        check("rst_in_ready",  64'(bus_a.in_ready),  64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        @(posedge clock);
        #1;

        // directed vectors: value and exact latency
        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // randomized traffic with random backpressure
        sb_on = 1'b1;
        done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send_a(2'($urandom_range(0, 3)), W'($urandom), SW'($urandom_range(0, W - 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clock);
                    #1;
                    bus_a.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // back-to-back stream of 8
        out_cnt   = 0;
        first_out = -1;
        for (int i = 0; i < 8; i++)
            send_a(2'($urandom_range(0, 3)), W'($urandom), SW'($urandom_range(0, W - 1)));
        drain();
        check("b2b_count", 64'(out_cnt), 64'd8);
        check("b2b_span",  64'(last_out - first_out), 64'd7);

        // 3 in flight, output stalled for 5 cycles, a 4th request held by the source
        out_cnt = 0;
        send_a(2'b00, 32'h0000_00F1, 5'd4);
        send_a(2'b11, 32'hDEAD_BEEF, 5'd12);
        send_a(2'b10, 32'h8765_4321, 5'd7);
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_op     = 2'b01;
        bus_a.in_data   = 32'hCAFE_F00D;
        bus_a.in_shamt  = 5'd9;
        repeat (5) begin
            @(negedge clock);
            check("stall_in_ready", 64'(bus_a.in_ready), 64'd0);
        end
        @(posedge clock);
        #1;
        bus_a.out_ready = 1'b1;
        @(negedge clock);
        check("release_in_ready", 64'(bus_a.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus_a.in_valid = 1'b0;
        drain();
        check("stall_count", 64'(out_cnt), 64'd4);

        // reset with 2 requests in flight
        out_cnt = 0;
        send_a(2'b00, 32'h0000_0001, 5'd3);
        send_a(2'b01, 32'hFFFF_0000, 5'd8);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_in_ready", 64'(bus_a.in_ready), 64'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_out_valid", 64'(bus_a.out_valid), 64'd0);
        idle(6);
        check("midrst_no_stale", 64'(out_cnt), 64'd0);
        sb_on = 1'b0;

        // 8-bit instance without the mid register
        run_b("b_sra", 2'b10, 8'h90, 3'd3, {1'b0, 1'b0, 8'hF2});
        run_b("b_sll", 2'b00, 8'h81, 3'd1, {1'b1, 1'b0, 8'h02});
        run_b("b_ror", 2'b11, 8'h01, 3'd7, {1'b0, 1'b0, 8'h02});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
